// File: rtl/serial_cmd_parser.sv
// rtl/serial_cmd_parser.sv - 7-byte command frame parser with XOR checksum
// Optional inter-byte timeout enabled by defining TIMEOUT_EN.
module serial_cmd_parser #(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 69400,
   parameter int         TO_W      = 17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_byte,
   input  logic        rbyte_ready,
   output logic        cmd_valid,
   output logic [3:0]  cmd_op,
   output logic [1:0]  cmd_motor,
   output logic [31:0] cmd_data,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic        busy,
   output logic        timeout_p
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_CS} state_t;

   state_t      state, state_n;
   logic [1:0]  idx;
   logic [7:0]  acc;
   logic [3:0]  op_sh;
   logic [1:0]  motor_sh;
   logic [31:0] data_sh;
   logic        to_expire;
   logic        cs_hit, cs_miss;

   assign busy    = (state != S_IDLE);
   assign cs_hit  = rbyte_ready && (state == S_CS) && (rx_byte == acc);
   assign cs_miss = rbyte_ready && (state == S_CS) && (rx_byte != acc);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // A strobe always wins over a timeout expiring in the same cycle.
   always_comb begin
      state_n = state;
      if (rbyte_ready) begin
         case (state)
            S_IDLE:  if (rx_byte == SYNC_BYTE) state_n = S_HDR;
            S_HDR:   state_n = S_DATA;
            S_DATA:  if (idx == 2'd3) state_n = S_CS;
            S_CS:    state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end else if (to_expire) begin
         state_n = S_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd_valid <= 1'b0;
         cmd_op    <= 4'd0;
         cmd_motor <= 2'd0;
         cmd_data  <= 32'd0;
         frame_err <= 1'b0;
         err_cnt   <= 8'd0;
         idx       <= 2'd0;
         acc       <= 8'd0;
         op_sh     <= 4'd0;
         motor_sh  <= 2'd0;
         data_sh   <= 32'd0;
      end else begin
         cmd_valid <= cs_hit;
         frame_err <= cs_miss;
         if (cs_hit) begin
            cmd_op    <= op_sh;
            cmd_motor <= motor_sh;
            cmd_data  <= data_sh;
         end
         if (cs_miss && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
         if (rbyte_ready) begin
            case (state)
               S_IDLE: if (rx_byte == SYNC_BYTE) acc <= 8'd0;
               S_HDR: begin
                  // Header bits [3:2] are reserved but still feed the checksum.
                  op_sh    <= rx_byte[7:4];
                  motor_sh <= rx_byte[1:0];
                  acc      <= rx_byte;
                  idx      <= 2'd0;
               end
               S_DATA: begin
                  data_sh <= {data_sh[23:0], rx_byte};
                  acc     <= acc ^ rx_byte;
                  idx     <= idx + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   assign to_expire = !rbyte_ready && (state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         to_cnt    <= '0;
         timeout_p <= 1'b0;
      end else begin
         timeout_p <= to_expire;
         if (rbyte_ready || (state == S_IDLE)) to_cnt <= '0;
         else if (!to_expire)                  to_cnt <= to_cnt + TO_W'(1);
      end
   end
`else
   logic unused_to;

   assign unused_to = ^{TO_W'(TIMEOUT)};
   assign to_expire = 1'b0;
   assign timeout_p = 1'b0;
`endif

endmodule

// File: tb/tb_serial_cmd_parser.sv
// tb/tb_serial_cmd_parser.sv - directed scoreboard bench for serial_cmd_parser
// Timeout scenario follows TIMEOUT_EN when defined.
module tb_serial_cmd_parser;

   localparam int TIMEOUT = 69400;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_byte;
   logic        rbyte_ready;
   logic        cmd_valid;
   logic [3:0]  cmd_op;
   logic [1:0]  cmd_motor;
   logic [31:0] cmd_data;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic        busy;
   logic        timeout_p;

   int total = 0;
   int bad   = 0;
   int n_valid = 0, n_ferr = 0, n_to = 0;
   int n_exp_valid = 0, n_exp_ferr = 0;
   int exp_err = 0;
   logic [37:0] q[$];

   serial_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT(TIMEOUT), .TO_W(17)) dut (
      .clk(clk), .reset(reset), .rx_byte(rx_byte), .rbyte_ready(rbyte_ready),
      .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_motor(cmd_motor),
      .cmd_data(cmd_data), .frame_err(frame_err), .err_cnt(err_cnt),
      .busy(busy), .timeout_p(timeout_p)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every command pulse must match the oldest expected frame.
   always @(negedge clk) begin
      if (!reset) begin
         if (frame_err) n_ferr++;
         if (timeout_p) n_to++;
         if (cmd_valid) begin
            logic [37:0] e;
            n_valid++;
            total++;
            assert (q.size() != 0) else begin
               bad++;
               $error("FAIL unexpected_cmd observed=%0h expected=none", {cmd_op, cmd_motor, cmd_data});
            end
            if (q.size() != 0) begin
               e = q.pop_front();
               total++;
               assert ({cmd_op, cmd_motor, cmd_data} === e) else begin
                  bad++;
                  $error("FAIL cmd_fields observed=%0h expected=%0h", {cmd_op, cmd_motor, cmd_data}, e);
               end
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_byte     = b;
      rbyte_ready = 1'b1;
      @(posedge clk);
      #1;
      rbyte_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [31:0] d, input bit corrupt);
      logic [7:0] cs;
      cs = hdr ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if (corrupt) begin
         cs = cs ^ 8'h01;
         n_exp_ferr++;
         if (exp_err < 255) exp_err++;
      end else begin
         q.push_back({hdr[7:4], hdr[1:0], d});
         n_exp_valid++;
      end
      send_byte(8'hA5);
      send_byte(hdr);
      send_byte(d[31:24]);
      send_byte(d[23:16]);
      send_byte(d[15:8]);
      send_byte(d[7:0]);
      send_byte(cs);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_outs"}, {cmd_valid, cmd_op, cmd_motor, cmd_data, frame_err, err_cnt, busy, timeout_p}, 64'd0);
   endtask

   initial begin
      reset = 1'b1;
      rx_byte = 8'h00;
      rbyte_ready = 1'b0;
      idle(3);
      chk_reset_vals("reset");
      reset = 1'b0;
      idle(2);

      send_frame(8'h12, 32'h0000_01F4, 1'b0);
      chk("a_latency", cmd_valid, 1);
      chk("a_op", cmd_op, 4'h1);
      chk("a_motor", cmd_motor, 2'd2);
      chk("a_data", cmd_data, 32'h0000_01F4);
      chk("a_no_ferr", frame_err, 0);
      idle(1);
      chk("a_pulse_width", cmd_valid, 0);
      chk("a_idle_busy", busy, 0);

      send_frame(8'h12, 32'h0000_01F4, 1'b1);
      chk("bad_ferr", frame_err, 1);
      chk("bad_cnt", err_cnt, 8'd1);
      chk("bad_no_cmd", cmd_valid, 0);
      chk("bad_hold_data", cmd_data, 32'h0000_01F4);
      idle(1);
      chk("bad_pulse_width", frame_err, 0);

      send_byte(8'h00); chk("garb0_busy", busy, 0);
      send_byte(8'hFF); chk("garb1_busy", busy, 0);
      send_byte(8'h5A); chk("garb2_busy", busy, 0);
      send_frame(8'h12, 32'h0000_01F4, 1'b0);
      idle(2);

      send_frame(8'h12, 32'h0000_01F4, 1'b0);
      send_frame(8'h33, 32'hDEAD_BEEF, 1'b0);
      chk("b2b_op", cmd_op, 4'h3);
      chk("b2b_motor", cmd_motor, 2'd3);
      chk("b2b_data", cmd_data, 32'hDEAD_BEEF);
      idle(2);

      send_frame(8'hA5, 32'h0000_0000, 1'b0);
      chk("sync_as_hdr", {cmd_valid, cmd_op, cmd_motor}, {1'b1, 4'hA, 2'd1});
      idle(2);

      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h00);
`ifdef TIMEOUT_EN
      idle(TIMEOUT + 2);
      chk("to_pulses", n_to, 1);
      chk("to_busy", busy, 0);
      send_byte(8'h00); send_byte(8'h01); send_byte(8'hF4); send_byte(8'hE7);
      idle(2);
      chk("to_no_cmd", n_valid, n_exp_valid);
      chk("to_err_cnt", err_cnt, exp_err);
      send_frame(8'h12, 32'h0000_01F4, 1'b0);
      chk("to_recover", cmd_valid, 1);
`else
      idle(100);
      chk("noto_busy", busy, 1);
      chk("noto_pulses", n_to, 0);
      q.push_back({4'h1, 2'd2, 32'h0000_01F4});
      n_exp_valid++;
      send_byte(8'h00); send_byte(8'h01); send_byte(8'hF4); send_byte(8'hE7);
      chk("noto_complete", cmd_valid, 1);
`endif
      idle(2);

      send_byte(8'hA5); send_byte(8'h12); send_byte(8'h00); send_byte(8'h00);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid_reset");
      idle(2);
      chk_reset_vals("held_reset");
      reset = 1'b0;
      exp_err = 0;
      send_byte(8'h01); send_byte(8'hF4); send_byte(8'hE7);
      idle(2);
      chk_reset_vals("post_reset");
      chk("post_reset_cmds", n_valid, n_exp_valid);

      for (int i = 0; i < 300; i++) send_frame(8'h12, 32'h0000_01F4, 1'b1);
      idle(2);
      chk("sat_err_cnt", err_cnt, 8'd255);
      chk("sat_model", err_cnt, exp_err);
      chk("ferr_count", n_ferr, n_exp_ferr);
      chk("valid_count", n_valid, n_exp_valid);
      chk("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
